// File: rtl/gate_ctrl_param.sv
// Parking-gate access controller with a configurable PIN, a configurable
// wrong-attempt limit, one PIN attempt per enterPin press, and an optional
// auto-close timeout for the open gate.
//
// Ports:
//   Clk       - clock, rising edge
//   Reset     - asynchronous active-high reset
//   Vehiculo  - vehicle present at the gate
//   Termino   - vehicle finished passing
//   enterPin  - keypad enter button (level; one attempt per rising edge)
//   Pin       - keypad value, sampled on the enterPin rising edge
//   Cerrado   - gate closed            (registered)
//   Abierto   - gate open              (registered)
//   Alarma    - sticky wrong-PIN alarm (registered)
//   Bloqueo   - tailgating lock        (registered)
//   Intentos  - consecutive wrong attempts, saturating at MAX_TRIES (registered)
module gate_ctrl_param #(
    parameter int unsigned             PIN_WIDTH    = 8,
    parameter logic [PIN_WIDTH-1:0]    PIN_CORRECTO = PIN_WIDTH'(8'b00010000),
    parameter int unsigned             MAX_TRIES    = 3,
    parameter int unsigned             OPEN_TIMEOUT = 16,
    localparam int unsigned            CNT_W        = $clog2(MAX_TRIES + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Vehiculo,
    input  logic                 Termino,
    input  logic                 enterPin,
    input  logic [PIN_WIDTH-1:0] Pin,
    output logic                 Cerrado,
    output logic                 Abierto,
    output logic                 Alarma,
    output logic                 Bloqueo,
    output logic [CNT_W-1:0]     Intentos
);

    // Timer only has to hold 0 .. OPEN_TIMEOUT-1; keep at least one bit.
    localparam int unsigned TO_W    = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (OPEN_TIMEOUT == 0) ? 0 : OPEN_TIMEOUT - 1;

    localparam logic [TO_W-1:0]  TO_LAST_V = TO_W'(TO_LAST);
    localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(MAX_TRIES);

    typedef enum logic [1:0] {
        CERRADO    = 2'd0,
        ESPERA_PIN = 2'd1,
        ABIERTO    = 2'd2,
        BLOQUEO    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              enter_prev;
    logic [TO_W-1:0]   tmr;
    logic [TO_W-1:0]   tmr_n;
    logic [CNT_W-1:0]  intentos_n;
    logic              alarma_n;
    logic              attempt;
    logic              correcto;
    logic [CNT_W-1:0]  wrong_cnt;
    logic              wrong_alarm;

    // One attempt per press: only the enterPin rising edge counts.
    assign attempt  = enterPin & ~enter_prev;
    assign correcto = (Pin == PIN_CORRECTO);

    // State, timer, edge detector and Moore outputs decoded from next state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= CERRADO;
            enter_prev <= 1'b0;
            tmr        <= '0;
            Cerrado    <= 1'b1;
            Abierto    <= 1'b0;
            Alarma     <= 1'b0;
            Bloqueo    <= 1'b0;
            Intentos   <= '0;
        end else begin
            state      <= state_n;
            enter_prev <= enterPin;
            tmr        <= tmr_n;
            Cerrado    <= (state_n != ABIERTO);
            Abierto    <= (state_n == ABIERTO);
            Alarma     <= alarma_n;
            Bloqueo    <= (state_n == BLOQUEO);
            Intentos   <= intentos_n;
        end
    end

    // Next-state, attempt counter and alarm.
    always_comb begin
        state_n     = state;
        tmr_n       = '0;
        intentos_n  = Intentos;
        alarma_n    = Alarma;

        // Saturating wrong-attempt update; alarm raised when the limit is hit.
        wrong_cnt   = (Intentos == MAX_V) ? Intentos : Intentos + CNT_W'(1);
        wrong_alarm = Alarma | (wrong_cnt == MAX_V);

        case (state)
            CERRADO: begin
                if (Vehiculo) begin
                    state_n = ESPERA_PIN;
                end
            end

            ESPERA_PIN: begin
                // Attempt is evaluated before the vehicle leaving.
                if (attempt && correcto) begin
                    state_n    = ABIERTO;
                    intentos_n = '0;
                    alarma_n   = 1'b0;
                end else begin
                    if (attempt) begin
                        intentos_n = wrong_cnt;
                        alarma_n   = wrong_alarm;
                    end
                    if (!Vehiculo) begin
                        state_n = CERRADO;
                    end
                end
            end

            ABIERTO: begin
                // Termino takes priority over the timeout.
                if (Termino) begin
                    state_n = Vehiculo ? BLOQUEO : CERRADO;
                end else if ((OPEN_TIMEOUT != 0) && (tmr == TO_LAST_V)) begin
                    state_n = CERRADO;
                end else if (OPEN_TIMEOUT != 0) begin
                    tmr_n = tmr + TO_W'(1);
                end
            end

            BLOQUEO: begin
                if (attempt && correcto) begin
                    state_n    = CERRADO;
                    intentos_n = '0;
                    alarma_n   = 1'b0;
                end else if (attempt) begin
                    intentos_n = wrong_cnt;
                    alarma_n   = wrong_alarm;
                end
            end

            default: begin
                state_n = CERRADO;
            end
        endcase
    end

endmodule

// File: doc/gate_ctrl_param.md
Name: gate_ctrl_param

Overview:
- Parametrised parking-gate access controller; next generation of the team's fixed 8-bit-PIN gate FSM.
- Sits between the vehicle sensor, the PIN keypad and the gate actuator/alarm drivers; the existing gate bench drives it.
- Adds over the previous generation: configurable PIN width and value, configurable wrong-attempt limit, enterPin rising-edge detection (one attempt per press), open-gate timeout, and an attempt counter output.

Parameters:
- PIN_WIDTH, 8, width of Pin and PIN_CORRECTO.
- PIN_CORRECTO, 8'b00010000, accepted PIN value (PIN_WIDTH bits).
- MAX_TRIES, 3, wrong attempts that raise Alarma (>=1).
- OPEN_TIMEOUT, 16, cycles in ABIERTO without Termino before auto-close; 0 disables the timeout.
- CNT_W, $clog2(MAX_TRIES+1), width of Intentos (derived, not overridden).

Ports:
- Clk, input, 1, single clock, rising edge.
- Reset, input, 1, asynchronous, active-high reset.
- Vehiculo, input, 1, vehicle present at gate.
- Termino, input, 1, vehicle finished passing (nominally a 1-cycle pulse).
- enterPin, input, 1, keypad enter button (level, may be held several cycles).
- Pin, input, PIN_WIDTH, keypad value, sampled on the enterPin rising edge.
- Cerrado, output, 1, gate closed.
- Abierto, output, 1, gate open.
- Alarma, output, 1, wrong-PIN alarm.
- Bloqueo, output, 1, tailgating lock.
- Intentos, output, CNT_W, consecutive wrong-attempt count, saturating.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All outputs are registered (Moore). No combinational input-to-output path.
- Reset values:
  - State = CERRADO; Cerrado=1, Abierto=0, Alarma=0, Bloqueo=0, Intentos=0.
  - Timeout counter = 0; enter_prev = 0.
  - Reset asserted mid-operation aborts any state immediately, with no pending effects.
- Attempt detection:
  - enter_prev registers enterPin.
  - An attempt occurs at a rising Clk edge where enterPin=1 and enter_prev=0.
  - Holding enterPin high gives exactly one attempt. Pin changes without an enterPin edge are ignored.
  - correcto = (Pin == PIN_CORRECTO) at that edge.
- States (one-hot or binary, implementer's choice):
  - CERRADO: Cerrado=1. Vehiculo=1 -> ESPERA_PIN. Attempts are ignored.
  - ESPERA_PIN: Cerrado=1.
    - Correct attempt -> ABIERTO; Intentos cleared to 0; Alarma cleared.
    - Wrong attempt: Intentos += 1, saturating at MAX_TRIES. Alarma is set on the edge where Intentos reaches MAX_TRIES.
    - Vehiculo=0 with no attempt -> CERRADO; Intentos and Alarma are retained.
  - ABIERTO: Abierto=1, Cerrado=0. The timeout counter runs from 0 on entry.
    - Termino=1 and Vehiculo=0 -> CERRADO.
    - Termino=1 and Vehiculo=1 (tailgating) -> BLOQUEO.
    - OPEN_TIMEOUT!=0 and the counter reaches OPEN_TIMEOUT-1 with no Termino -> CERRADO.
    - Attempts are ignored.
  - BLOQUEO: Cerrado=1, Bloqueo=1.
    - Correct attempt -> CERRADO; Bloqueo cleared, Intentos=0, Alarma=0.
    - Wrong attempt: counts exactly as in ESPERA_PIN (may raise Alarma). State stays BLOQUEO.
    - Termino and Vehiculo are ignored.
- Alarma is a sticky flag independent of state. It is cleared only by a correct attempt or by Reset.
- Latency: one cycle from the qualifying input edge to the output change.
- Simultaneous events:
  - Termino beats timeout in the same cycle.
  - An attempt and Vehiculo falling in the same cycle in ESPERA_PIN: the attempt is evaluated first. Correct -> ABIERTO; wrong -> counted, then -> CERRADO.
- Intentos never exceeds MAX_TRIES. Further wrong attempts hold it there with Alarma=1.

Test Plan:
- Normal entry: Reset, Vehiculo=1, enterPin pulse with Pin=8'h10 -> Abierto=1 next cycle, Intentos=0. Then Vehiculo=0, Termino=1 for 1 cycle -> Cerrado=1, Abierto=0.
- Alarm: Vehiculo=1, four enterPin pulses with Pin=8'hFF -> Intentos=1,2,3,3; Alarma=1 from the third pulse. Then pulse with 8'h10 -> Abierto=1, Alarma=0, Intentos=0.
- Tailgating: in ABIERTO, Vehiculo=1 and Termino=1 together -> Bloqueo=1, Cerrado=1. Wrong PIN -> Intentos=1, still BLOQUEO. Correct PIN -> Bloqueo=0, CERRADO.
- Edge detection: hold enterPin=1 for 5 cycles with Pin=8'hFF -> Intentos=1 only. Change Pin to 8'h10 while enterPin is still held -> no open until the next rising edge.
- Timeout: OPEN_TIMEOUT=4, open the gate, no Termino -> Abierto=1 for exactly 4 cycles, then Cerrado=1. Repeat with OPEN_TIMEOUT=0 -> gate stays open indefinitely.
- Parametrisation and reset: PIN_WIDTH=16, PIN_CORRECTO=16'hBEEF, MAX_TRIES=2 -> Alarma after 2 wrong attempts; 16'hBEEF opens. Assert Reset asynchronously mid-ABIERTO -> all outputs at reset values immediately, before the next Clk edge.
